// File: rtl/apu_pkg.sv
// Constants shared by the APU channels: timer period table, length table and
// the noise LFSR seed.
package apu_pkg;

   localparam logic [14:0] LFSR_RESET = 15'h0001;

   localparam logic [11:0] PERIOD_TABLE [16] = '{
      12'd4,   12'd8,   12'd16,  12'd32,  12'd64,   12'd96,   12'd128,  12'd160,
      12'd202, 12'd254, 12'd380, 12'd508, 12'd762,  12'd1016, 12'd2034, 12'd4068
   };

   localparam logic [7:0] LENGTH_TABLE [32] = '{
      8'd10, 8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
      8'd160, 8'd8,  8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
      8'd12, 8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
      8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
   };

endpackage

// File: rtl/noise_envelope.sv
// Volume envelope: start flag, period divider and 4-bit decay level.
// The same block serves the rectangle channel.
module noise_envelope
   import apu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_i,
   input  logic       restart_i,
   input  logic       loop_i,
   input  logic [3:0] period_i,
   output logic [3:0] decay_o
);

   logic       start_q, start_d;
   logic [3:0] divider_q, divider_d;
   logic [3:0] decay_q, decay_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q   <= 1'b0;
         divider_q <= 4'd0;
         decay_q   <= 4'd0;
      end else begin
         start_q   <= start_d;
         divider_q <= divider_d;
         decay_q   <= decay_d;
      end
   end

   // A restart arriving with the tick is consumed in the same cycle.
   always_comb begin
      start_d   = start_q | restart_i;
      divider_d = divider_q;
      decay_d   = decay_q;
      if (tick_i) begin
         if (start_q || restart_i) begin
            start_d   = 1'b0;
            decay_d   = 4'hF;
            divider_d = period_i;
         end else if (divider_q == 4'd0) begin
            divider_d = period_i;
            if (decay_q != 4'd0) begin
               decay_d = decay_q - 4'd1;
            end else if (loop_i) begin
               decay_d = 4'hF;
            end
         end else begin
            divider_d = divider_q - 4'd1;
         end
      end
   end

   assign decay_o = decay_q;

endmodule

// File: rtl/noise.sv
// Noise channel: register decode, rate-programmable 15-bit LFSR, length
// counter and envelope, producing a registered 4-bit amplitude.
module noise
   import apu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable_240hz,
   input  logic       enable_120hz,
   input  logic [7:0] reg_400c,
   input  logic [7:0] reg_400e,
   input  logic [7:0] reg_400f,
   input  logic       reg_change,
   output logic [3:0] noise_out
);

   logic [14:0] lfsr_q, lfsr_d;
   logic [11:0] timer_q, timer_d;
   logic [7:0]  length_q, length_d;
   logic [3:0]  out_q, out_d;
   logic [3:0]  decay;
   logic        fb;
   logic        unused_bits;

   assign unused_bits = ^{reg_400e[6:4], reg_400f[2:0]};

   noise_envelope u_env (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (enable_240hz),
      .restart_i (reg_change),
      .loop_i    (reg_400c[5]),
      .period_i  (reg_400c[3:0]),
      .decay_o   (decay)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q   <= LFSR_RESET;
         timer_q  <= 12'd0;
         length_q <= 8'd0;
         out_q    <= 4'd0;
      end else begin
         lfsr_q   <= lfsr_d;
         timer_q  <= timer_d;
         length_q <= length_d;
         out_q    <= out_d;
      end
   end

   // The period index is only sampled at reload, so a change never cuts
   // the running count short.
   always_comb begin
      fb      = lfsr_q[0] ^ (reg_400e[7] ? lfsr_q[6] : lfsr_q[1]);
      timer_d = timer_q - 12'd1;
      lfsr_d  = lfsr_q;
      if (timer_q == 12'd0) begin
         timer_d = PERIOD_TABLE[reg_400e[3:0]] - 12'd1;
         lfsr_d  = {fb, lfsr_q[14:1]};
      end

      length_d = length_q;
      if (reg_change) begin
         length_d = LENGTH_TABLE[reg_400f[7:3]];
      end else if (enable_120hz && (length_q != 8'd0) && !reg_400c[5]) begin
         length_d = length_q - 8'd1;
      end

      out_d = 4'd0;
      if (!lfsr_q[0] && (length_q != 8'd0)) begin
         out_d = reg_400c[4] ? reg_400c[3:0] : decay;
      end
   end

   assign noise_out = out_q;

endmodule
